// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer write-port front end:
//   FB_ADDR_W / FB_DATA_W  default pixel address / pixel data widths
//   fb_state_e             write-port arbitration state
//   pixel_t                one RGB888 pixel
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_ADDR_W = 20;
  localparam int FB_DATA_W = 24;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_CLEAR = 2'd1,
    FB_DONE  = 2'd2
  } fb_state_e;

  typedef logic [FB_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/fb_write_ctrl_if.sv
// -----------------------------------------------------------------------------
// fb_write_ctrl_if
// Bus bundle around the framebuffer controller.
//   Raster write : wr_valid, wr_ready, wr_addr, wr_data
//   Scanout read : rd_req, rd_addr, rd_valid, rd_data
//   Memory port  : mem_read, mem_out, mem_writing, mem_waddr, mem_wdata
// Modports:
//   master - raster/scanout/memory side (drives requests and mem_out)
//   slave  - the controller (fb_write_ctrl)
// -----------------------------------------------------------------------------
interface fb_write_ctrl_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] mem_read;
  logic [DATA_W-1:0] mem_out;
  logic              mem_writing;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_out,
    input  wr_ready, rd_valid, rd_data, mem_read, mem_writing, mem_waddr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, mem_out,
    output wr_ready, rd_valid, rd_data, mem_read, mem_writing, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/fb_clear_seq.sv
// -----------------------------------------------------------------------------
// fb_clear_seq
// Address counter and colour latch for the clear sweep.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       restart the sweep at address 0 and latch color
//   color       sweep colour, sampled on start
//   advance     a clear write was issued this cycle; step the counter
//   addr, data  address / colour of the current clear write
//   last        current address is CLEAR_LAST
// -----------------------------------------------------------------------------
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int                ADDR_W     = FB_ADDR_W,
  parameter int                DATA_W     = FB_DATA_W,
  parameter logic [ADDR_W-1:0] CLEAR_LAST = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] color,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic [ADDR_W-1:0] count_p0;
  logic [DATA_W-1:0] color_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p0 <= '0;
      color_p0 <= '0;
    end else if (start) begin
      count_p0 <= '0;
      color_p0 <= color;
    end else if (advance && !last) begin
      // Parks at CLEAR_LAST so the counter never wraps.
      count_p0 <= count_p0 + 1'b1;
    end
  end

  assign addr = count_p0;
  assign data = color_p0;
  assign last = (count_p0 == CLEAR_LAST);

endmodule

// File: rtl/fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// fb_write_ctrl
// Front end for the framebuffer memory: arbitrates the single write port
// between the rasterizer stream and the clear sweep, and passes scanout reads
// straight through with a one-cycle valid strobe.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_start  one-cycle pulse starting a sweep (ignored unless idle)
//   clear_color  sweep colour, sampled with an accepted clear_start
//   busy         sweep in progress
//   clear_done   one-cycle pulse after the last clear write is issued
//   bus          fb_write_ctrl_if.slave (raster write, scanout read, memory)
// Build option:
//   FB_WRITE_CTRL_RASTER_PRIORITY_EN - raster writes keep wr_ready high during
//   a sweep and preempt that cycle's clear write (the sweep is stretched).
// -----------------------------------------------------------------------------
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int                ADDR_W     = FB_ADDR_W,
  parameter int                DATA_W     = FB_DATA_W,
  parameter logic [ADDR_W-1:0] CLEAR_LAST = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_start,
  input  logic [DATA_W-1:0]    clear_color,
  output logic                 busy,
  output logic                 clear_done,
  fb_write_ctrl_if.slave       bus
);

  fb_state_e         state, state_next;
  logic              seq_start, seq_advance, seq_last;
  logic [ADDR_W-1:0] seq_addr;
  logic [DATA_W-1:0] seq_data;
  logic              raster_wr, clear_wr;

  logic              wr_en_p1;
  logic [ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              rd_vld_p1;

  fb_clear_seq #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CLEAR_LAST (CLEAR_LAST)
  ) u_clear_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (seq_start),
    .color   (clear_color),
    .advance (seq_advance),
    .addr    (seq_addr),
    .data    (seq_data),
    .last    (seq_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FB_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.wr_ready = 1'b0;
    seq_start    = 1'b0;
    seq_advance  = 1'b0;
    clear_wr     = 1'b0;
    busy         = 1'b0;
    clear_done   = 1'b0;
    case (state)
      FB_IDLE: begin
        // A raster write in the same cycle as clear_start still goes through.
        bus.wr_ready = 1'b1;
        if (clear_start) begin
          seq_start  = 1'b1;
          state_next = FB_CLEAR;
        end
      end
      FB_CLEAR: begin
        busy = 1'b1;
`ifdef FB_WRITE_CTRL_RASTER_PRIORITY_EN
        bus.wr_ready = 1'b1;
        if (!bus.wr_valid) begin
          clear_wr    = 1'b1;
          seq_advance = 1'b1;
          if (seq_last) state_next = FB_DONE;
        end
`else
        clear_wr    = 1'b1;
        seq_advance = 1'b1;
        if (seq_last) state_next = FB_DONE;
`endif
      end
      FB_DONE: begin
        bus.wr_ready = 1'b1;
        clear_done   = 1'b1;
        state_next   = FB_IDLE;
      end
      default: state_next = FB_IDLE;
    endcase
  end

  assign raster_wr = bus.wr_valid && bus.wr_ready;

  // ---- stage p1: registered memory write port and read strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_p1  <= 1'b0;
      waddr_p1  <= '0;
      wdata_p1  <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      wr_en_p1  <= raster_wr || clear_wr;
      rd_vld_p1 <= bus.rd_req;
      if (raster_wr) begin
        waddr_p1 <= bus.wr_addr;
        wdata_p1 <= bus.wr_data;
      end else if (clear_wr) begin
        waddr_p1 <= seq_addr;
        wdata_p1 <= seq_data;
      end
    end
  end

  assign bus.mem_writing = wr_en_p1;
  assign bus.mem_waddr   = waddr_p1;
  assign bus.mem_wdata   = wdata_p1;

  // Memory read data is already registered, so it lines up with rd_vld_p1.
  assign bus.mem_read = bus.rd_addr;
  assign bus.rd_valid = rd_vld_p1;
  assign bus.rd_data  = bus.mem_out;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_write_ctrl
// Bench for fb_write_ctrl with CLEAR_LAST = 15 and a 256-word memory model.
// Expected memory writes and read data are queued by the stimulus side and
// consumed by an independent monitor.
// -----------------------------------------------------------------------------
module tb_fb_write_ctrl;
  import fb_pkg::*;

  localparam int                AW  = 20;
  localparam int                DW  = 24;
  localparam logic [AW-1:0]     CL  = 20'd15;
  localparam int                NCL = 16;
`ifdef FB_WRITE_CTRL_RASTER_PRIORITY_EN
  localparam int PRI = 1;
`else
  localparam int PRI = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_start = 1'b0;
  pixel_t        clear_color = '0;
  logic          busy, clear_done;

  fb_write_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_write_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_LAST(CL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .busy        (busy),
    .clear_done  (clear_done),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory with registered read; a same-edge write is not seen by the read.
  logic [DW-1:0] mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_writing) mem[bus.mem_waddr[7:0]] <= bus.mem_wdata;
    bus.mem_out <= mem[bus.mem_read[7:0]];
  end

  // Reference model state
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  logic [43:0]   rq[$];   // expected raster writes {addr,data}
  logic [43:0]   cq[$];   // expected clear writes {addr,data}
  logic [DW-1:0] rdq[$];  // expected read data
  logic [7:0]    written[$];

  int vectors = 0, miscompares = 0;
  int busy_cycles = 0, done_cnt = 0, done_before = 0;
  logic [43:0] w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_writing) begin
        w = {bus.mem_waddr, bus.mem_wdata};
        if (rq.size() > 0 && rq[0] == w) begin
          void'(rq.pop_front());
          vectors++;
        end else if (cq.size() > 0) begin
          check("mem_write", 64'(w), 64'(cq.pop_front()));
        end else begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got %0h expected none at %0t", w, $time);
        end
      end
      if (bus.rd_valid) begin
        if (rdq.size() > 0) check("rd_data", 64'(bus.rd_data), 64'(rdq.pop_front()));
        else fail_now("unexpected_rd_valid");
      end
      if (busy) busy_cycles++;
      if (clear_done) done_cnt++;
`ifdef FB_WRITE_CTRL_RASTER_PRIORITY_EN
      check("wr_ready", 64'(bus.wr_ready), 64'd1);
`else
      check("wr_ready", 64'(bus.wr_ready), 64'(!busy));
`endif
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic raster_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.wr_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      rq.push_back({a, d});
      ref_mem[a[7:0]] = d;
      written.push_back(a[7:0]);
    end else fail_now("wr_accept_timeout");
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic start_clear(input logic [DW-1:0] color);
    @(posedge clk); #1;
    clear_start = 1'b1; clear_color = color;
    busy_cycles = 0; done_before = done_cnt;
    for (int a = 0; a < NCL; a++) begin
      cq.push_back({AW'(a), color});
      ref_mem[a] = color;
    end
    @(posedge clk); #1;
    clear_start = 1'b0;
  endtask

  task automatic wait_clear(input int extra);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (done_cnt > done_before) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("clear_done_timeout");
    repeat (3) @(negedge clk);
    check("clear_done_count", 64'(done_cnt - done_before), 64'd1);
    check("sweep_len", 64'(busy_cycles), 64'(NCL + extra));
  endtask

  task automatic do_read(input logic [7:0] a);
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rd_addr = AW'(a);
    rdq.push_back(ref_mem[a]);
  endtask

  task automatic rd_idle();
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    logic [7:0] a;
    logic [DW-1:0] d;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_clear_done", 64'(clear_done), 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_mem_writing", 64'(bus.mem_writing), 64'd0);
    check("rst_mem_waddr", 64'(bus.mem_waddr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed single raster write
    @(posedge clk); #1;
    bus.wr_valid = 1'b1; bus.wr_addr = 20'h00010; bus.wr_data = 24'hFF0000;
    @(negedge clk);
    check("dir_wr_ready", 64'(bus.wr_ready), 64'd1);
    rq.push_back({20'h00010, 24'hFF0000});
    ref_mem[8'h10] = 24'hFF0000;
    @(posedge clk); #1 bus.wr_valid = 1'b0;
    @(negedge clk);
    check("dir_mem_writing", 64'(bus.mem_writing), 64'd1);
    check("dir_mem_waddr", 64'(bus.mem_waddr), 64'h10);
    check("dir_mem_wdata", 64'(bus.mem_wdata), 64'hFF0000);
    @(negedge clk);
    check("dir_mem_idle", 64'(bus.mem_writing), 64'd0);

    // Random raster writes (addresses outside the sweep and 0x10)
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(32, 255));
      d = 24'($urandom);
      raster_write(AW'(a), d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (3) @(posedge clk);

    // Random read-back, mixed back-to-back and gapped
    for (int i = 0; i < 12; i++) begin
      do_read(written[$urandom_range(0, written.size() - 1)]);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1 bus.rd_req = 1'b0;
      end
    end
    rd_idle();

    // Plain clear sweep, then read back
    start_clear(24'h123456);
    wait_clear(0);
    do_read(8'd5);
    rd_idle();
    for (int i = 0; i < 4; i++) do_read(8'(i));
    rd_idle();
    for (int i = 0; i < NCL; i++) do_read(8'(i));
    rd_idle();

    // Raster write held during a sweep
    start_clear(24'h00FF00);
    raster_write(20'h00040, 24'hA5A5A5);
    wait_clear(PRI);
    repeat (2) @(posedge clk);
    do_read(8'h40);
    rd_idle();

    // Ignored second clear_start, reads during the sweep
    start_clear(24'h0000FF);
    repeat (3) @(posedge clk);
    #1 clear_start = 1'b1; clear_color = 24'hABCDEF;
    @(posedge clk); #1 clear_start = 1'b0;
    do_read(8'h10);
    do_read(8'h40);
    rd_idle();
    wait_clear(0);
    for (int i = 0; i < NCL; i++) do_read(8'(i));
    rd_idle();

    // Reset in the middle of a sweep
    start_clear(24'h777777);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.mem_writing && bus.mem_waddr == 20'd7) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("sweep_addr7_timeout");
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_mem_writing", 64'(bus.mem_writing), 64'd0);
    check("midrst_clear_done", 64'(clear_done), 64'd0);
    cq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_clear_done_hold", 64'(clear_done), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - done_before), 64'd0);
    start_clear(24'h5A5A5A);
    wait_clear(0);
    for (int i = 0; i < NCL; i++) do_read(8'(i));
    rd_idle();

    // Everything expected must have appeared
    repeat (3) @(posedge clk);
    check("rq_empty", 64'(rq.size()), 64'd0);
    check("cq_empty", 64'(cq.size()), 64'd0);
    check("rdq_empty", 64'(rdq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fb_write_ctrl.md
Name: fb_write_ctrl

Overview:
- Front-end controller for the single-port-write / single-port-read framebuffer memory (24-bit pixels, 20-bit address).
- Shares the one write port between the rasterizer pixel stream (valid/ready) and an internal clear sequencer that sweeps a solid colour over the buffer.
- Passes scanout reads through to the memory and returns them with a valid strobe.
- Sits between rasterizer/scanout and the framebuffer memory.

Parameters:
ADDR_W, 20, pixel address width
DATA_W, 24, pixel data width (RGB888)
CLEAR_LAST, 20'hFFFFF, last address written by a clear sweep (sweep covers 0..CLEAR_LAST inclusive)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clear_start  in  1  one-cycle pulse: begin clear sweep
clear_color  in  DATA_W  colour for the sweep, sampled on the accepted clear_start
busy  out  1  high while the sweep is active
clear_done  out  1  one-cycle pulse when the sweep finishes
wr_valid  in  1  rasterizer write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_W  rasterizer pixel address
wr_data  in  DATA_W  rasterizer pixel colour
rd_req  in  1  scanout read request
rd_addr  in  ADDR_W  scanout read address
rd_valid  out  1  rd_data valid
rd_data  out  DATA_W  read pixel
mem_read  out  ADDR_W  to memory read address
mem_out  in  DATA_W  from memory registered read data
mem_writing  out  1  to memory write enable
mem_waddr  out  ADDR_W  to memory write address
mem_wdata  out  DATA_W  to memory write data

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, latched colour 0; busy=0, clear_done=0, rd_valid=0, mem_writing=0, mem_waddr=0, mem_wdata=0.
- FSM states:
  - IDLE: wr_ready=1. An accepted raster write registers {mem_writing=1, mem_waddr=wr_addr, mem_wdata=wr_data} at the next edge. The memory commits the write one edge later.
  - IDLE + clear_start: go to CLEAR, latch clear_color, counter=0, busy=1 from the next cycle. If clear_start and wr_valid are both high, the raster write is still accepted that cycle. The sweep starts the following cycle.
  - CLEAR: wr_ready=0 (raster stalls; wr_addr/wr_data must be held by the source). Each cycle registers a write of the latched colour to address counter, then counter+1.
  - CLEAR exit: on the cycle the write to CLEAR_LAST is issued, go to DONE. Counter never wraps past CLEAR_LAST.
  - DONE: one cycle; clear_done=1, busy=0, wr_ready=1, then IDLE.
- Sweep length: exactly CLEAR_LAST+1 write cycles.
- clear_start in CLEAR or DONE is ignored (no restart, no queueing).
- mem_writing is 0 on every cycle without an accepted write.
- Read path:
  - mem_read = rd_addr (combinational pass-through).
  - rd_valid is rd_req registered one cycle; rd_data = mem_out.
  - Latency: 1 clock. Reads are never stalled, including during CLEAR.
- Read of an address being written in the same cycle returns the old contents; no forwarding.
- Reset mid-sweep: sweep abandoned, memory partially cleared, no clear_done.

Optional Feature:
- Macro: FB_WRITE_CTRL_RASTER_PRIORITY_EN.
- Defined:
  - wr_ready stays 1 in CLEAR.
  - A raster write preempts the sweep for that cycle: the counter holds and the clear write is deferred.
  - Sweep length becomes CLEAR_LAST+1 plus the number of preempting writes.
  - busy remains 1 throughout.
  - Raster writes to addresses not yet swept are overwritten later by the sweep.
- Undefined: raster fully stalled during CLEAR as above.

Decomposition:
- Shared package fb_pkg:
  - FB_ADDR_W=20, FB_DATA_W=24 constants.
  - State enum {FB_IDLE, FB_CLEAR, FB_DONE}.
  - Pixel typedef (DATA_W-bit).
- One natural sub-module: fb_clear_seq, holding the counter, colour latch and last-address compare, with start/advance inputs and addr/data/last outputs. Arbitration and the memory-port registers stay in the top.

Test Plan:
- Reset then wr_valid=1, wr_addr=20'h00010, wr_data=24'hFF0000 -> wr_ready=1; next cycle mem_writing=1, mem_waddr=20'h00010, mem_wdata=24'hFF0000; cycle after, mem_writing=0.
- CLEAR_LAST=15, clear_start with clear_color=24'h123456 -> busy=1 for 16 cycles, mem_waddr 0..15 each with 24'h123456; clear_done pulses once; all 16 memory words read back 24'h123456.
- During the sweep, wr_valid=1 held -> wr_ready=0 until DONE, then the write is accepted exactly once. With RASTER_PRIORITY_EN: accepted immediately, sweep stretches by 1 cycle.
- rd_req=1, rd_addr=5 after the clear -> next cycle rd_valid=1, rd_data=24'h123456. Back-to-back reads of addresses 0..3 -> four consecutive valid beats.
- Second clear_start mid-sweep -> ignored; still exactly 16 writes and one clear_done.
- rst_n=0 at sweep address 7 -> busy=0 and mem_writing=0 immediately (async); no clear_done; a new clear_start after reset restarts from address 0.
